// File: rtl/serial_signed_cmp.sv
// Bit-serial MSB-first magnitude comparator, signed or unsigned, four selectable relations.
// Define CMP_EARLY_EXIT_EN to finish at the first differing bit instead of after WIDTH bits.
`timescale 1ns/1ps
module serial_signed_cmp #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             lt,
    output logic             eq
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d, gt_dec_q, gt_dec_d;
    logic             result_q, result_d, lt_q, lt_d, eq_q, eq_d;

    logic bit_a, bit_b, dec_n, gt_n, finish;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_dec_d  = gt_dec_q;
        result_d  = result_q;
        lt_d      = lt_q;
        eq_d      = eq_q;

        bit_a = a_q[idx_q];
        bit_b = b_q[idx_q];
        dec_n = decided_q | (bit_a ^ bit_b);
        gt_n  = decided_q ? gt_dec_q : (bit_a & ~bit_b);
`ifdef CMP_EARLY_EXIT_EN
        finish = (idx_q == '0) | (dec_n & ~decided_q);
`else
        finish = (idx_q == '0);
`endif

        case (state_q)
            RUN: begin
                decided_d = dec_n;
                gt_dec_d  = gt_n;
                idx_d     = idx_q - IW'(1);
                if (finish) begin
                    // Flags include the bit examined on this very edge.
                    state_d = DONE;
                    lt_d    = dec_n & ~gt_n;
                    eq_d    = ~dec_n;
                    case (mode_q)
                        2'b00:   result_d = ~(dec_n & ~gt_n);
                        2'b01:   result_d = dec_n & gt_n;
                        2'b10:   result_d = ~dec_n;
                        default: result_d = dec_n;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q != RUN) && start) begin
            // Inverting the MSB maps two's complement onto offset binary.
            state_d   = RUN;
            a_d       = {x[WIDTH-1] ^ is_signed, x[WIDTH-2:0]};
            b_d       = {y[WIDTH-1] ^ is_signed, y[WIDTH-2:0]};
            mode_d    = mode;
            idx_d     = IW'(WIDTH - 1);
            decided_d = 1'b0;
            gt_dec_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_dec_q  <= 1'b0;
            result_q  <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_dec_q  <= gt_dec_d;
            result_q  <= result_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign lt     = lt_q;
    assign eq     = eq_q;
endmodule

// File: tb/tb_serial_signed_cmp.sv
// Directed bench for serial_signed_cmp at WIDTH=6 and WIDTH=16; latency expectations follow CMP_EARLY_EXIT_EN.
`timescale 1ns/1ps
module tb_serial_signed_cmp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start6, s6, busy6, done6, res6, lt6, eq6;
    logic [5:0] x6, y6;
    logic [1:0] m6;
    logic        start16, s16, busy16, done16, res16, lt16, eq16;
    logic [15:0] x16, y16;
    logic [1:0]  m16;

    serial_signed_cmp #(.WIDTH(6)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .x(x6), .y(y6), .is_signed(s6), .mode(m6),
        .busy(busy6), .done(done6), .result(res6), .lt(lt6), .eq(eq6)
    );
    serial_signed_cmp #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .x(x16), .y(y16), .is_signed(s16), .mode(m16),
        .busy(busy16), .done(done16), .result(res16), .lt(lt16), .eq(eq16)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // k = 1-based position of first difference from the MSB (w when equal)
    function automatic int exp_lat(input int w, input int k);
`ifdef CMP_EARLY_EXIT_EN
        return k + 1;
`else
        return w + 1;
`endif
    endfunction

    task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic sg, input logic [1:0] md);
        if (sel == 0) begin
            x6 = a[5:0]; y6 = b[5:0]; s6 = sg; m6 = md; start6 = 1'b1;
        end else begin
            x16 = a; y16 = b; s16 = sg; m16 = md; start16 = 1'b1;
        end
    endtask

    task automatic wait_done(input int sel, output int lat, output int bcnt);
        @(posedge clk);
        #1 start6 = 1'b0; start16 = 1'b0;
        lat = 0; bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((sel == 0) ? busy6 : busy16) bcnt++;
            if ((sel == 0) ? done6 : done16) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic op(input string tag, input int sel, input logic [15:0] a, input logic [15:0] b,
                      input logic sg, input logic [1:0] md, input int k,
                      input logic er, input logic elt, input logic eeq, input bit b2b);
        int lat, bcnt, w, el;
        w  = (sel == 0) ? 6 : 16;
        el = exp_lat(w, k);
        if (!b2b) @(negedge clk);
        issue(sel, a, b, sg, md);
        wait_done(sel, lat, bcnt);
        check({tag, ".lat"},    lat, el);
        check({tag, ".busy"},   bcnt, el - 1);
        check({tag, ".result"}, (sel == 0) ? res6 : res16, er);
        check({tag, ".lt"},     (sel == 0) ? lt6 : lt16, elt);
        check({tag, ".eq"},     (sel == 0) ? eq6 : eq16, eeq);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start6 = 0; x6 = 0; y6 = 0; s6 = 0; m6 = 0;
        start16 = 0; x16 = 0; y16 = 0; s16 = 0; m16 = 0;
        repeat (3) @(posedge clk);
        // reset and start together: reset wins
        @(negedge clk);
        start6 = 1'b1;
        @(negedge clk);
        check("rst.busy", busy6, 0);
        check("rst.done", done6, 0);
        check("rst.result", res6, 0);
        check("rst.lt", lt6, 0);
        check("rst.eq", eq6, 0);
        check("rst16.busy", busy16, 0);
        start6 = 1'b0;
        reset  = 1'b0;

        op("s_m1_ge_p1", 0, 6'b111111, 6'b000001, 1, 2'b00, 1, 0, 1, 0, 0);
        op("u_63_ge_1",  0, 6'b111111, 6'b000001, 0, 2'b00, 1, 1, 0, 0, 0);
        op("eq_gt",      0, 6'b101010, 6'b101010, 0, 2'b01, 6, 0, 0, 1, 0);
        op("eq_eq_b2b",  0, 6'b101010, 6'b101010, 0, 2'b10, 6, 1, 0, 1, 1);
        op("s16_gt",     1, 16'h8000, 16'h7FFF, 1, 2'b01, 1, 0, 1, 0, 0);
        op("s16_gt_swap",1, 16'h7FFF, 16'h8000, 1, 2'b01, 1, 1, 0, 0, 0);
        op("u_ne_equal", 0, 6'd5, 6'd5, 0, 2'b11, 6, 0, 0, 1, 0);
        op("s_ne_2_3",   0, 6'd2, 6'd3, 1, 2'b11, 6, 1, 1, 0, 0);
        op("s_2_ge_m2",  0, 6'd2, 6'b111110, 1, 2'b00, 1, 1, 0, 0, 0);

        // Restarts and operand changes during RUN are ignored
        @(negedge clk);
        issue(0, 6'b010101, 6'b010101, 0, 2'b10);
        @(posedge clk);
        #1 start6 = 1'b0; x6 = 6'd0; y6 = 6'h3F; m6 = 2'b01;
        dones = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start6 = 1'b1;
            if (done6) dones++;
        end
        start6 = 1'b0;
        for (int n = 5; n <= 15; n++) begin
            @(negedge clk);
            if (done6) dones++;
        end
        check("ign.dones", dones, 1);
        check("ign.result", res6, 1);
        check("ign.eq", eq6, 1);
        check("ign.lt", lt6, 0);

        // Reset during RUN
        @(negedge clk);
        issue(0, 6'b001100, 6'b001100, 0, 2'b10);
        @(posedge clk);
        #1 start6 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid.busy_before", busy6, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid.busy", busy6, 0);
        check("mid.result", res6, 0);
        check("mid.lt", lt6, 0);
        check("mid.eq", eq6, 0);
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done6) dones++;
        end
        check("mid.no_done", dones, 0);
        op("after_rst", 0, 6'd3, 6'd2, 0, 2'b01, 6, 1, 0, 0, 0);

        op("ee_diff",  0, 6'b100000, 6'b000000, 0, 2'b00, 1, 1, 0, 0, 0);
        op("ee_equal", 0, 6'd5, 6'd5, 0, 2'b00, 6, 1, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_signed_cmp.md
# serial_signed_cmp

Parametrised, multi-cycle magnitude comparator that generalises the team's fixed 6-bit signed greater-or-equal block. It compares two WIDTH-bit operands MSB-first, one bit per clock, in signed or unsigned mode. It produces one of four relational results selected per operation. It sits beside the ALU flag logic, where the area of a wide parallel comparator is not justified and a start/busy/done handshake is acceptable.

## Interface
- WIDTH, 6, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- x  input  WIDTH  operand A; sampled with start.
- y  input  WIDTH  operand B; sampled with start.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- mode  input  2  00 A>=B, 01 A>B, 10 A==B, 11 A!=B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  1  selected relation; held until the next accepted start.
- lt  output  1  A<B flag; held with result.
- eq  output  1  A==B flag; held with result.

## Operation
- FSM states:
  - IDLE: busy=0. start=1 → RUN.
  - RUN: busy=1, one bit per cycle. After the last bit → DONE.
  - DONE: done=1 for exactly one cycle. Next state is RUN if start=1 in this cycle, otherwise IDLE.
- On accept, the block latches x, y, mode and is_signed, and clears the internal decided and gt_dec flags. The bit index is set to WIDTH-1.
- Signed mode inverts the MSB of both latched operands, converting them to offset binary. The rest of the datapath is purely unsigned.
- Each RUN cycle examines bit[idx] of both operands:
  - If decided=0 and the bits differ: set decided=1 and gt_dec=A bit.
  - The bit index then decrements.
- Final flags: eq = ~decided; lt = decided & ~gt_dec; gt = decided & gt_dec.
- result by mode: 00 → ~lt; 01 → gt; 10 → eq; 11 → ~eq.
- result, lt and eq update only on the edge that enters DONE. They stay stable through IDLE and the following RUN until the next DONE.
- start while busy=1 is ignored; there is no queuing.
- Input changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, lt=0, eq=0. The internal index and flags are cleared.
- Latency with the feature disabled:
  - start is sampled at edge E0.
  - busy is high from the cycle after E0 for WIDTH cycles.
  - done is high in cycle WIDTH+1 after E0.
  - Latency is fixed and independent of the data.
- Throughput: accepting start in the DONE cycle gives back-to-back operations every WIDTH+1 cycles.
- Reset asserted mid-RUN or in DONE: the block returns to IDLE on that edge. done does not pulse and the outputs return to their reset values.
- reset and start high on the same edge: reset wins.

## Configuration
- CMP_EARLY_EXIT_EN defined:
  - RUN moves to DONE on the edge that sets decided=1, i.e. at the first differing bit.
  - Latency is k+1 cycles, where k is the 1-based position of the first difference counted from the MSB. Equal operands take WIDTH+1 cycles.
  - busy lasts k cycles.
- CMP_EARLY_EXIT_EN undefined: fixed WIDTH+1 latency as above. Results are identical in both builds; only timing differs.

## Test plan
- WIDTH=6, signed, mode=00, x=6'b111111 (-1), y=6'b000001 (+1) → done at cycle 7, result=0, lt=1, eq=0. Same operands with is_signed=0 → result=1, lt=0.
- WIDTH=6, x=y=6'b101010, mode=01 then mode=10 back-to-back (second start in the DONE cycle) → results 0 then 1, eq=1 both times, done pulses exactly 7 cycles apart.
- WIDTH=16, signed, mode=01, x=16'h8000 (-32768), y=16'h7FFF → result=0, lt=1. Swap the operands → result=1.
- Start pulsed again on cycles 2–5 of a WIDTH=6 compare → ignored; exactly one done pulse; result matches the first operands.
- Reset asserted on cycle 3 of a RUN → busy=0, done never pulses, result=lt=eq=0. A new start afterward completes normally.
- CMP_EARLY_EXIT_EN, WIDTH=6, unsigned, x=6'b100000, y=6'b000000, mode=00 → busy for 1 cycle, done at cycle 2, result=1. Equal operands → done at cycle 7.
